// File: rtl/fir_decim_out_if.sv
// rtl/fir_decim_out_if.sv - sample/handshake bundle for fir_decim_out
// Purpose: groups the filter-side input stream, the valid/ready output stream
//   and the overflow status/clear lines of fir_decim_out.
// Signals:
//   in_data/in_valid        filter sample stream (no backpressure)
//   out_data/out_valid/out_ready  decimated, requantised output stream
//   fifo_level              output FIFO occupancy, 0..FIFO_DEPTH
//   overflow/clear_ovf      sticky drop flag and its synchronous clear
// Modports: master = producer/consumer side, slave = fir_decim_out.
interface fir_decim_out_if #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 12,
  parameter int FIFO_DEPTH = 8
) ();
  logic signed [DATA_WIDTH-1:0]       in_data;
  logic                               in_valid;
  logic signed [OUT_WIDTH-1:0]        out_data;
  logic                               out_valid;
  logic                               out_ready;
  logic [$clog2(FIFO_DEPTH):0]        fifo_level;
  logic                               overflow;
  logic                               clear_ovf;

  modport master (
    output in_data, in_valid, out_ready, clear_ovf,
    input  out_data, out_valid, fifo_level, overflow
  );

  modport slave (
    input  in_data, in_valid, out_ready, clear_ovf,
    output out_data, out_valid, fifo_level, overflow
  );
endinterface

// File: rtl/fir_decim_out.sv
// rtl/fir_decim_out.sv - decimate, requantise and buffer fir_filter output
// Purpose: keeps every DECIM-th valid sample, rounds it (half-up) by an
//   arithmetic right shift of SHIFT, saturates to OUT_WIDTH bits and queues it
//   in a FIFO_DEPTH-entry FIFO toward a valid/ready consumer.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   fir_decim_out_if.slave: in_data/in_valid in, out_data/out_valid out,
//         out_ready in, fifo_level out, overflow out, clear_ovf in
module fir_decim_out #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 12,
  parameter int DECIM      = 4,
  parameter int SHIFT      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input logic            clk,
  input logic            rst,
  fir_decim_out_if.slave bus
);

  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);

  // Rounding offset 2^(SHIFT-1), or 0 when SHIFT is 0.
  localparam int RND  = (1 << SHIFT) >> 1;
  localparam int OMAX = (1 << (OUT_WIDTH - 1)) - 1;
  localparam int OMIN = -(1 << (OUT_WIDTH - 1));

  localparam logic signed [DATA_WIDTH:0] RND_V  = (DATA_WIDTH + 1)'(RND);
  localparam logic signed [DATA_WIDTH:0] OMAX_V = (DATA_WIDTH + 1)'(OMAX);
  localparam logic signed [DATA_WIDTH:0] OMIN_V = (DATA_WIDTH + 1)'(OMIN);

  logic [CNT_W-1:0]            cnt;
  logic                        s1_valid;
  logic signed [OUT_WIDTH-1:0] s1_data;

  logic signed [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]               wr_ptr;
  logic [AW-1:0]               rd_ptr;
  logic [AW:0]                 level;
  logic                        ovf;

  logic                        keep;
  logic signed [DATA_WIDTH:0]  t_w;
  logic signed [DATA_WIDTH:0]  r_w;
  logic signed [OUT_WIDTH-1:0] q_w;
  logic                        not_empty;
  logic                        rd;
  logic                        wr;
  logic                        drop;

  assign keep = bus.in_valid && (cnt == '0);

  // One extra bit of headroom so the rounding add cannot wrap.
  assign t_w = $signed({bus.in_data[DATA_WIDTH-1], bus.in_data}) + RND_V;
  assign r_w = t_w >>> SHIFT;

  always_comb begin
    q_w = r_w[OUT_WIDTH-1:0];
    if (r_w > OMAX_V)      q_w = OMAX_V[OUT_WIDTH-1:0];
    else if (r_w < OMIN_V) q_w = OMIN_V[OUT_WIDTH-1:0];
  end

  assign not_empty = (level != '0);
  assign rd        = not_empty && bus.out_ready;
  // A read in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr        = s1_valid && ((level != (AW + 1)'(FIFO_DEPTH)) || rd);
  assign drop      = s1_valid && !wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      s1_valid <= 1'b0;
      s1_data  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      ovf      <= 1'b0;
    end else begin
      if (bus.in_valid) begin
        if (cnt == CNT_W'(DECIM - 1)) cnt <= '0;
        else                          cnt <= cnt + 1'b1;
      end

      s1_valid <= keep;
      if (keep) s1_data <= q_w;

      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;

      case ({wr, rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      // A drop in the same cycle as a clear leaves the flag set.
      if (drop)               ovf <= 1'b1;
      else if (bus.clear_ovf) ovf <= 1'b0;
    end
  end

  // Storage needs no reset: the head is masked to 0 while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= s1_data;
  end

  assign bus.out_valid  = not_empty;
  assign bus.out_data   = not_empty ? mem[rd_ptr] : '0;
  assign bus.fifo_level = level;
  assign bus.overflow   = ovf;

endmodule

// File: tb/tb_fir_decim_out.sv
// tb/tb_fir_decim_out.sv - self-checking bench for fir_decim_out
module tb_fir_decim_out;

  logic clk;
  logic rst;

  fir_decim_out_if #(.DATA_WIDTH(16), .OUT_WIDTH(12), .FIFO_DEPTH(8)) bus ();

  fir_decim_out #(
    .DATA_WIDTH(16), .OUT_WIDTH(12), .DECIM(4), .SHIFT(4), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int din;
    int exp;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int got[$];

  // Capture every accepted output while inputs are stable mid-cycle.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready)
      got.push_back(int'(bus.out_data));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int d, input logic v);
    bus.in_data  = 16'(d);
    bus.in_valid = v;
    tick();
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.clear_ovf = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    got.delete();
  endtask

  task automatic check_out(input string name, input int exp[$]);
    check({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s_%0d", name, i), got[i], exp[i]);
  endtask

  initial begin
    vec_t rq[6];
    int   exp_q[$];

    rq[0] = '{din: 1000,   exp: 63};
    rq[1] = '{din: -1000,  exp: -62};
    rq[2] = '{din: 24,     exp: 2};
    rq[3] = '{din: -24,    exp: -1};
    rq[4] = '{din: 32767,  exp: 2047};
    rq[5] = '{din: -32768, exp: -2048};

    bus.out_ready = 1'b0;
    do_reset();
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_fifo_level", int'(bus.fifo_level), 0);
    check("rst_overflow", int'(bus.overflow), 0);
    check("rst_out_data", int'(bus.out_data), 0);

    // Decimation with continuous input.
    bus.out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      feed(16 * k, 1'b1);
      if (k == 0) check("dec_lat_early", int'(bus.out_valid), 0);
      if (k == 1) check("dec_lat_valid", int'(bus.out_valid), 1);
    end
    idle(4);
    exp_q = '{0, 4, 8, 12};
    check_out("dec", exp_q);
    check("dec_overflow", int'(bus.overflow), 0);

    // Round and saturate, table driven; three filler samples per kept one.
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      feed(rq[i].din, 1'b1);
      for (int j = 0; j < 3; j++) feed(0, 1'b1);
    end
    idle(4);
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(rq[i].exp);
    check_out("rq", exp_q);

    // Gapped input: invalid cycles carry junk and must not advance the phase.
    do_reset();
    bus.out_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      feed(16 * n, 1'b1);
      feed(16'sh7ff0, 1'b0);
    end
    idle(4);
    exp_q = '{0, 4, 8, 12};
    check_out("gap", exp_q);

    // Backpressure and overflow.
    do_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 40; k++) begin
      feed(16 * k, 1'b1);
      if (k == 29) check("bp_level_full", int'(bus.fifo_level), 8);
      if (k == 32) check("bp_ovf_before", int'(bus.overflow), 0);
      if (k == 33) check("bp_ovf_set", int'(bus.overflow), 1);
    end
    check("bp_level_end", int'(bus.fifo_level), 8);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    idle(12);
    exp_q = '{0, 4, 8, 12, 16, 20, 24, 28};
    check_out("bp", exp_q);
    check("bp_level_drained", int'(bus.fifo_level), 0);
    check("bp_ovf_sticky", int'(bus.overflow), 1);
    bus.clear_ovf = 1'b1;
    tick();
    bus.clear_ovf = 1'b0;
    check("bp_ovf_cleared", int'(bus.overflow), 0);

    // Full FIFO with read and write in the same cycle.
    do_reset();
    for (int k = 0; k < 36; k++) begin
      bus.out_ready = (k == 33);
      feed(16 * k, 1'b1);
      if (k == 32) check("full_level_pre", int'(bus.fifo_level), 8);
      if (k == 33) begin
        check("full_level_rw", int'(bus.fifo_level), 8);
        check("full_ovf_rw", int'(bus.overflow), 0);
      end
    end
    bus.out_ready = 1'b1;
    idle(12);
    exp_q = '{0, 4, 8, 12, 16, 20, 24, 28, 32};
    check_out("full", exp_q);
    check("full_level_end", int'(bus.fifo_level), 0);

    // Reset mid-stream with 3 queued and one sample in s1.
    do_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 13; k++) feed(16 * k, 1'b1);
    check("mid_level_pre", int'(bus.fifo_level), 3);
    rst = 1'b1;
    feed(16 * 13, 1'b1);
    rst = 1'b0;
    check("mid_out_valid", int'(bus.out_valid), 0);
    check("mid_level", int'(bus.fifo_level), 0);
    check("mid_overflow", int'(bus.overflow), 0);
    feed(1600, 1'b1);
    check("mid_lat_early", int'(bus.out_valid), 0);
    feed(0, 1'b0);
    check("mid_lat_valid", int'(bus.out_valid), 1);
    check("mid_data", int'(bus.out_data), 100);
    check("mid_level_one", int'(bus.fifo_level), 1);
    idle(2);
    check("mid_no_ghost", int'(bus.fifo_level), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
